// File: rtl/ob_mk_deque_mc_if.sv
// Command and status bundle for the multi-channel market deque ob_mk_deque_mc.
interface ob_mk_deque_mc_if #(
  parameter int unsigned C  = 2,
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 64,
  parameter int unsigned QW = 16,
  parameter int unsigned AW = QW + $clog2(N + 1)
);
  localparam int unsigned CHW = (C > 1) ? $clog2(C) : 1;

  logic            cmd_vld;
  logic [CHW-1:0]  cmd_ch;
  logic [2:0]      cmd_op;
  logic [W-1:0]    cmd_data;

  logic [C-1:0]    head_vld_r;
  logic [C*W-1:0]  head_r;
  logic [C*W-1:0]  tail_r;
  logic [C-1:0]    empty_w;
  logic [C-1:0]    full_w;
  logic [C*AW-1:0] quantity_r;
  logic            err_r;

  modport master (
    output cmd_vld, cmd_ch, cmd_op, cmd_data,
    input  head_vld_r, head_r, tail_r, empty_w, full_w, quantity_r, err_r
  );

  modport slave (
    input  cmd_vld, cmd_ch, cmd_op, cmd_data,
    output head_vld_r, head_r, tail_r, empty_w, full_w, quantity_r, err_r
  );
endinterface

// File: rtl/ob_mk_deque_mc.sv
// Multi-channel market deque: C circular order queues with per-channel quantity,
// in-place head partial fill and illegal-command reporting. Optional FOK probe: OB_MK_DEQUE_MC_FOK_EN.
module ob_mk_deque_mc #(
  parameter int unsigned C  = 2,
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 64,
  parameter int unsigned QW = 16,
  parameter int unsigned AW = QW + $clog2(N + 1),
  localparam int unsigned CHW = (C > 1) ? $clog2(C) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ob_mk_deque_mc_if.slave   bus
`ifdef OB_MK_DEQUE_MC_FOK_EN
  ,
  input  logic              fok_vld,
  input  logic [CHW-1:0]    fok_ch,
  input  logic [AW-1:0]     fok_qty,
  output logic              fok_ok_r,
  output logic              fok_rsp_vld_r
`endif
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSHF = 3'd1;
  localparam logic [2:0] OP_POPF  = 3'd2;
  localparam logic [2:0] OP_PUSHB = 3'd3;
  localparam logic [2:0] OP_POPB  = 3'd4;
  localparam logic [2:0] OP_RED   = 3'd5;

  logic [W-1:0]  mem    [C][N];
  logic [PW-1:0] rd_ptr [C];
  logic [PW-1:0] wr_ptr [C];
  logic [CW-1:0] cnt    [C];
  logic [AW-1:0] qty    [C];
  logic          err_q;

  logic           ch_ok;
  logic [CHW-1:0] chi;
  logic [PW-1:0]  rd_m1, wr_m1;
  logic [W-1:0]   head_e, tail_e, red_e;
  logic [QW-1:0]  hq, amt;
  logic           sel_empty, sel_full;
  logic           do_pf, do_pb, do_popf, do_popb, do_red, bad;

  // Decode the command against the selected channel's registered state.
  always_comb begin
    ch_ok     = 32'(bus.cmd_ch) < C;
    chi       = ch_ok ? bus.cmd_ch : '0;
    rd_m1     = rd_ptr[chi] - 1'b1;
    wr_m1     = wr_ptr[chi] - 1'b1;
    head_e    = mem[chi][rd_ptr[chi]];
    tail_e    = mem[chi][wr_m1];
    hq        = head_e[QW-1:0];
    amt       = bus.cmd_data[QW-1:0];
    red_e     = head_e;
    red_e[QW-1:0] = hq - amt;
    sel_empty = (cnt[chi] == '0);
    sel_full  = (cnt[chi] == CW'(N));
    do_pf = 1'b0; do_pb = 1'b0; do_popf = 1'b0; do_popb = 1'b0; do_red = 1'b0; bad = 1'b0;
    if (bus.cmd_vld) begin
      if (!ch_ok) begin
        bad = 1'b1;
      end else begin
        case (bus.cmd_op)
          OP_NOP:   ;
          OP_PUSHF: if (sel_full)  bad = 1'b1; else do_pf   = 1'b1;
          OP_PUSHB: if (sel_full)  bad = 1'b1; else do_pb   = 1'b1;
          OP_POPF:  if (sel_empty) bad = 1'b1; else do_popf = 1'b1;
          OP_POPB:  if (sel_empty) bad = 1'b1; else do_popb = 1'b1;
          OP_RED: begin
            // Emptiness is checked before the zero-amount no-op.
            if (sel_empty)        bad     = 1'b1;
            else if (amt == '0)   ;
            else if (amt < hq)    do_red  = 1'b1;
            else if (amt == hq)   do_popf = 1'b1;
            else                  bad     = 1'b1;
          end
          default:  bad = 1'b1;
        endcase
      end
    end
  end

  // Storage is deliberately unreset; empty gating masks stale contents.
  always_ff @(posedge clk) begin
    if (do_pf)       mem[chi][rd_m1]       <= bus.cmd_data;
    else if (do_pb)  mem[chi][wr_ptr[chi]] <= bus.cmd_data;
    else if (do_red) mem[chi][rd_ptr[chi]] <= red_e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < C; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        cnt[c]    <= '0;
        qty[c]    <= '0;
      end
      err_q <= 1'b0;
    end else begin
      err_q <= bad;
      if (do_pf) begin
        rd_ptr[chi] <= rd_m1;
        cnt[chi]    <= cnt[chi] + 1'b1;
        qty[chi]    <= qty[chi] + AW'(bus.cmd_data[QW-1:0]);
      end else if (do_pb) begin
        wr_ptr[chi] <= wr_ptr[chi] + 1'b1;
        cnt[chi]    <= cnt[chi] + 1'b1;
        qty[chi]    <= qty[chi] + AW'(bus.cmd_data[QW-1:0]);
      end else if (do_popf) begin
        rd_ptr[chi] <= rd_ptr[chi] + 1'b1;
        cnt[chi]    <= cnt[chi] - 1'b1;
        qty[chi]    <= qty[chi] - AW'(hq);
      end else if (do_popb) begin
        wr_ptr[chi] <= wr_m1;
        cnt[chi]    <= cnt[chi] - 1'b1;
        qty[chi]    <= qty[chi] - AW'(tail_e[QW-1:0]);
      end else if (do_red) begin
        qty[chi]    <= qty[chi] - AW'(amt);
      end
    end
  end

  logic [C-1:0]    head_vld_pk, empty_pk, full_pk;
  logic [C*W-1:0]  head_pk, tail_pk;
  logic [C*AW-1:0] qty_pk;

  always_comb begin
    head_vld_pk = '0; empty_pk = '0; full_pk = '0;
    head_pk = '0; tail_pk = '0; qty_pk = '0;
    for (int unsigned c = 0; c < C; c++) begin
      empty_pk[c]    = (cnt[c] == '0);
      full_pk[c]     = (cnt[c] == CW'(N));
      head_vld_pk[c] = !empty_pk[c];
      head_pk[c*W +: W]  = empty_pk[c] ? '0 : mem[c][rd_ptr[c]];
      tail_pk[c*W +: W]  = empty_pk[c] ? '0 : mem[c][PW'(wr_ptr[c] - 1'b1)];
      qty_pk[c*AW +: AW] = qty[c];
    end
  end

  assign bus.head_vld_r = head_vld_pk;
  assign bus.head_r     = head_pk;
  assign bus.tail_r     = tail_pk;
  assign bus.empty_w    = empty_pk;
  assign bus.full_w     = full_pk;
  assign bus.quantity_r = qty_pk;
  assign bus.err_r      = err_q;

`ifdef OB_MK_DEQUE_MC_FOK_EN
  logic           fok_ch_ok;
  logic [CHW-1:0] fchi;
  assign fok_ch_ok = 32'(fok_ch) < C;
  assign fchi      = fok_ch_ok ? fok_ch : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fok_ok_r      <= 1'b0;
      fok_rsp_vld_r <= 1'b0;
    end else begin
      fok_rsp_vld_r <= fok_vld;
      fok_ok_r      <= fok_vld && fok_ch_ok && (qty[fchi] >= fok_qty);
    end
  end
`endif
endmodule

// File: tb/tb_ob_mk_deque_mc.sv
// Randomized self-checking bench for ob_mk_deque_mc against a queue-based reference model.
module tb_ob_mk_deque_mc;
  localparam int unsigned C   = 2;
  localparam int unsigned N   = 8;
  localparam int unsigned W   = 64;
  localparam int unsigned QW  = 16;
  localparam int unsigned AW  = QW + $clog2(N + 1);
  localparam int unsigned CHW = (C > 1) ? $clog2(C) : 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ob_mk_deque_mc_if #(.C(C), .N(N), .W(W), .QW(QW), .AW(AW)) bus ();

`ifdef OB_MK_DEQUE_MC_FOK_EN
  logic           fok_vld;
  logic [CHW-1:0] fok_ch;
  logic [AW-1:0]  fok_qty;
  logic           fok_ok_r, fok_rsp_vld_r;
`endif

  ob_mk_deque_mc #(.C(C), .N(N), .W(W), .QW(QW), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave)
`ifdef OB_MK_DEQUE_MC_FOK_EN
    ,
    .fok_vld       (fok_vld),
    .fok_ch        (fok_ch),
    .fok_qty       (fok_qty),
    .fok_ok_r      (fok_ok_r),
    .fok_rsp_vld_r (fok_rsp_vld_r)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef logic [W-1:0] q_t [$];
  q_t   mq [C];
  logic exp_err;

  function automatic logic [W-1:0] mk(input logic [QW-1:0] q);
    logic [W-1:0] e;
    e = {$urandom(), $urandom()};
    e[QW-1:0] = q;
    return e;
  endfunction

  function automatic logic [AW-1:0] m_qty(input int c);
    logic [AW-1:0] s = '0;
    foreach (mq[c][i]) s += AW'(mq[c][i][QW-1:0]);
    return s;
  endfunction

  function automatic logic [W-1:0] m_head(input int c);
    return (mq[c].size() == 0) ? '0 : mq[c][0];
  endfunction

  function automatic logic [W-1:0] m_tail(input int c);
    return (mq[c].size() == 0) ? '0 : mq[c][mq[c].size()-1];
  endfunction

  function automatic logic [W-1:0] d_head(input int c);
    return bus.head_r[c*W +: W];
  endfunction

  function automatic logic [W-1:0] d_tail(input int c);
    return bus.tail_r[c*W +: W];
  endfunction

  function automatic logic [AW-1:0] d_qty(input int c);
    return bus.quantity_r[c*AW +: AW];
  endfunction

  task automatic model_cmd(input int c, input logic [2:0] op, input logic [W-1:0] d);
    logic [W-1:0]  t;
    logic [QW-1:0] a, h;
    exp_err = 1'b0;
    if (c >= int'(C)) begin
      exp_err = 1'b1;
      return;
    end
    case (op)
      3'd0: ;
      3'd1: if (mq[c].size() == N) exp_err = 1'b1; else mq[c].push_front(d);
      3'd2: if (mq[c].size() == 0) exp_err = 1'b1; else void'(mq[c].pop_front());
      3'd3: if (mq[c].size() == N) exp_err = 1'b1; else mq[c].push_back(d);
      3'd4: if (mq[c].size() == 0) exp_err = 1'b1; else void'(mq[c].pop_back());
      3'd5: begin
        if (mq[c].size() == 0) exp_err = 1'b1;
        else begin
          t = mq[c][0];
          h = t[QW-1:0];
          a = d[QW-1:0];
          if (a == 0) ;
          else if (a < h) begin
            t[QW-1:0] = h - a;
            mq[c][0] = t;
          end else if (a == h) void'(mq[c].pop_front());
          else exp_err = 1'b1;
        end
      end
      default: exp_err = 1'b1;
    endcase
  endtask

  task automatic cmd(input int c, input logic [2:0] op, input logic [W-1:0] d);
    bus.cmd_vld  = 1'b1;
    bus.cmd_ch   = CHW'(c);
    bus.cmd_op   = op;
    bus.cmd_data = d;
    model_cmd(c, op, d);
    @(posedge clk); #1;
    bus.cmd_vld = 1'b0;
    bus.cmd_op  = 3'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cmd_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < int'(C); c++) mq[c].delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.head_vld_r !== '0) begin bad++; $display("FAIL reset_head_vld got=%b exp=0", bus.head_vld_r); end
    total++; if (bus.empty_w !== '1) begin bad++; $display("FAIL reset_empty got=%b exp=all1", bus.empty_w); end
    total++; if (bus.full_w !== '0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full_w); end
    total++; if (bus.quantity_r !== '0) begin bad++; $display("FAIL reset_qty got=%h exp=0", bus.quantity_r); end
    total++; if (bus.head_r !== '0 || bus.tail_r !== '0) begin bad++; $display("FAIL reset_head_tail got=%h/%h exp=0", bus.head_r, bus.tail_r); end
    total++; if (bus.err_r !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err_r); end
  endtask

  task automatic test_push_back();
    logic [W-1:0] e10, e30;
    e10 = mk(16'd10);
    e30 = mk(16'd30);
    cmd(0, 3'd3, e10);
    cmd(0, 3'd3, mk(16'd20));
    cmd(0, 3'd3, e30);
    total++; if (d_qty(0) !== AW'(60)) begin bad++; $display("FAIL pb_qty got=%0d exp=60", d_qty(0)); end
    total++; if (d_head(0) !== e10) begin bad++; $display("FAIL pb_head got=%h exp=%h", d_head(0), e10); end
    total++; if (d_tail(0) !== e30) begin bad++; $display("FAIL pb_tail got=%h exp=%h", d_tail(0), e30); end
    total++; if (bus.empty_w[1] !== 1'b1 || d_qty(1) !== '0) begin bad++; $display("FAIL pb_ch1_untouched got empty=%b qty=%0d exp=1/0", bus.empty_w[1], d_qty(1)); end
    total++; if (bus.head_vld_r !== 2'b01) begin bad++; $display("FAIL pb_head_vld got=%b exp=01", bus.head_vld_r); end
  endtask

`ifdef OB_MK_DEQUE_MC_FOK_EN
  task automatic test_fok();
    fok_vld = 1'b1; fok_ch = '0; fok_qty = AW'(60);
    @(posedge clk); #1;
    total++; if (fok_rsp_vld_r !== 1'b1 || fok_ok_r !== 1'b1) begin bad++; $display("FAIL fok_60 got vld=%b ok=%b exp=1/1", fok_rsp_vld_r, fok_ok_r); end
    fok_qty = AW'(61);
    @(posedge clk); #1;
    total++; if (fok_rsp_vld_r !== 1'b1 || fok_ok_r !== 1'b0) begin bad++; $display("FAIL fok_61 got vld=%b ok=%b exp=1/0", fok_rsp_vld_r, fok_ok_r); end
    // Same-cycle PopFront on ch0: compare must see the pre-update 60.
    fok_qty = AW'(60);
    cmd(0, 3'd2, '0);
    total++; if (fok_ok_r !== 1'b1) begin bad++; $display("FAIL fok_preupdate got=%b exp=1", fok_ok_r); end
    fok_vld = 1'b0;
    @(posedge clk); #1;
    total++; if (fok_rsp_vld_r !== 1'b0 || fok_ok_r !== 1'b0) begin bad++; $display("FAIL fok_idle got vld=%b ok=%b exp=0/0", fok_rsp_vld_r, fok_ok_r); end
  endtask
`endif

  task automatic test_wrap_push_front();
    logic [W-1:0] e;
    e = mk(16'd5);
    cmd(1, 3'd1, e);
    total++; if (d_head(1) !== e || d_tail(1) !== e) begin bad++; $display("FAIL wrap_head_tail got=%h/%h exp=%h", d_head(1), d_tail(1), e); end
    total++; if (d_qty(1) !== AW'(5) || bus.err_r !== 1'b0) begin bad++; $display("FAIL wrap_qty got qty=%0d err=%b exp=5/0", d_qty(1), bus.err_r); end
    cmd(1, 3'd4, '0);
    total++; if (bus.empty_w[1] !== 1'b1 || d_qty(1) !== '0 || bus.err_r !== 1'b0) begin bad++; $display("FAIL wrap_popback got empty=%b qty=%0d err=%b exp=1/0/0", bus.empty_w[1], d_qty(1), bus.err_r); end
  endtask

  task automatic test_full();
    logic [AW-1:0] q_before;
    logic [W-1:0]  t_before;
    while (mq[0].size() < N) cmd(0, 3'd3, mk(16'($urandom_range(1, 50))));
    total++; if (bus.full_w[0] !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", bus.full_w[0]); end
    q_before = m_qty(0);
    t_before = m_tail(0);
    cmd(0, 3'd3, mk(16'd7));
    total++; if (bus.err_r !== 1'b1) begin bad++; $display("FAIL full_err got=%b exp=1", bus.err_r); end
    total++; if (d_qty(0) !== q_before || d_tail(0) !== t_before || bus.full_w[0] !== 1'b1) begin bad++; $display("FAIL full_nochange got qty=%0d tail=%h exp=%0d/%h", d_qty(0), d_tail(0), q_before, t_before); end
    cmd(0, 3'd0, '0);
    total++; if (bus.err_r !== 1'b0) begin bad++; $display("FAIL full_err_pulse got=%b exp=0", bus.err_r); end
  endtask

  task automatic test_reduce();
    logic [W-1:0] e;
    do_reset();
    e = mk(16'd10);
    cmd(0, 3'd3, e);
    cmd(0, 3'd3, mk(16'd5));
    cmd(0, 3'd5, W'(4));
    total++; if (d_head(0) !== {e[W-1:QW], 16'd6} || d_qty(0) !== AW'(11)) begin bad++; $display("FAIL red_partial got head=%h qty=%0d exp=%h/11", d_head(0), d_qty(0), {e[W-1:QW], 16'd6}); end
    cmd(0, 3'd5, W'(6));
    total++; if (d_head(0) !== m_head(0) || d_head(0) !== d_tail(0) || d_qty(0) !== AW'(5)) begin bad++; $display("FAIL red_pop got head=%h qty=%0d exp=%h/5", d_head(0), d_qty(0), m_head(0)); end
    cmd(0, 3'd5, W'(7));
    total++; if (bus.err_r !== 1'b1 || d_qty(0) !== AW'(5) || d_head(0) !== m_head(0)) begin bad++; $display("FAIL red_over got err=%b qty=%0d exp=1/5", bus.err_r, d_qty(0)); end
    cmd(0, 3'd5, W'(2));
    total++; if (d_head(0)[QW-1:0] !== 16'd3 || d_tail(0)[QW-1:0] !== 16'd3 || d_qty(0) !== AW'(3)) begin bad++; $display("FAIL red_single got h=%0d t=%0d qty=%0d exp=3/3/3", d_head(0)[QW-1:0], d_tail(0)[QW-1:0], d_qty(0)); end
  endtask

  task automatic test_illegal();
    cmd(1, 3'd2, '0);
    total++; if (bus.err_r !== 1'b1 || bus.empty_w[1] !== 1'b1 || d_qty(1) !== '0) begin bad++; $display("FAIL ill_pop_empty got err=%b empty=%b exp=1/1", bus.err_r, bus.empty_w[1]); end
    cmd(0, 3'd6, mk(16'd1));
    total++; if (bus.err_r !== 1'b1 || d_qty(0) !== m_qty(0) || d_head(0) !== m_head(0)) begin bad++; $display("FAIL ill_op6 got err=%b qty=%0d exp=1/%0d", bus.err_r, d_qty(0), m_qty(0)); end
    cmd(0, 3'd7, mk(16'd1));
    total++; if (bus.err_r !== 1'b1 || d_qty(0) !== m_qty(0)) begin bad++; $display("FAIL ill_op7 got err=%b qty=%0d exp=1/%0d", bus.err_r, d_qty(0), m_qty(0)); end
  endtask

  task automatic test_random();
    int r, c;
    logic [2:0] op;
    logic [W-1:0] d;
    do_reset();
    for (int it = 0; it < 600; it++) begin
      r = int'($urandom_range(0, 15));
      c = int'($urandom_range(0, C - 1));
      case (r)
        0, 1, 2, 3: op = 3'd3;
        4, 5:       op = 3'd1;
        6, 7:       op = 3'd2;
        8, 15:      op = 3'd4;
        9, 10, 11:  op = 3'd5;
        12:         op = 3'd0;
        13:         op = 3'd6;
        default:    op = 3'd7;
      endcase
      d = (op == 3'd5) ? W'($urandom_range(0, 30)) : mk(16'($urandom_range(0, 40)));
      cmd(c, op, d);
      total++; if (bus.err_r !== exp_err) begin bad++; $display("FAIL rnd_err it=%0d got=%b exp=%b", it, bus.err_r, exp_err); end
      for (int k = 0; k < int'(C); k++) begin
        total++;
        if (d_head(k) !== m_head(k) || d_tail(k) !== m_tail(k) || d_qty(k) !== m_qty(k) ||
            bus.empty_w[k] !== (mq[k].size() == 0) || bus.full_w[k] !== (mq[k].size() == N) ||
            bus.head_vld_r[k] !== (mq[k].size() != 0)) begin
          bad++;
          $display("FAIL rnd_state it=%0d ch=%0d got head=%h tail=%h qty=%0d e=%b f=%b exp head=%h tail=%h qty=%0d size=%0d",
                   it, k, d_head(k), d_tail(k), d_qty(k), bus.empty_w[k], bus.full_w[k],
                   m_head(k), m_tail(k), m_qty(k), mq[k].size());
        end
      end
    end
  endtask

  task automatic test_async_reset();
    cmd(0, 3'd3, mk(16'd9));
    cmd(1, 3'd3, mk(16'd4));
    bus.cmd_vld = 1'b1; bus.cmd_ch = '0; bus.cmd_op = 3'd3; bus.cmd_data = mk(16'd3);
`ifdef OB_MK_DEQUE_MC_FOK_EN
    fok_vld = 1'b1; fok_ch = '0; fok_qty = '0;
    @(posedge clk); #1;
`endif
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.head_vld_r !== '0 || bus.quantity_r !== '0 || bus.err_r !== 1'b0 || bus.empty_w !== '1) begin bad++; $display("FAIL arst_now got vld=%b qty=%h err=%b empty=%b exp=0/0/0/1", bus.head_vld_r, bus.quantity_r, bus.err_r, bus.empty_w); end
    total++; if (bus.head_r !== '0 || bus.tail_r !== '0) begin bad++; $display("FAIL arst_data got=%h/%h exp=0", bus.head_r, bus.tail_r); end
`ifdef OB_MK_DEQUE_MC_FOK_EN
    total++; if (fok_ok_r !== 1'b0 || fok_rsp_vld_r !== 1'b0) begin bad++; $display("FAIL arst_fok got ok=%b vld=%b exp=0/0", fok_ok_r, fok_rsp_vld_r); end
    fok_vld = 1'b0;
`endif
    @(posedge clk); #1;
    bus.cmd_vld = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < int'(C); c++) mq[c].delete();
    @(posedge clk); #1;
    total++; if (bus.head_vld_r !== '0 || bus.quantity_r !== '0) begin bad++; $display("FAIL arst_lost got vld=%b qty=%h exp=0/0", bus.head_vld_r, bus.quantity_r); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cmd_vld = 1'b0; bus.cmd_ch = '0; bus.cmd_op = 3'd0; bus.cmd_data = '0;
`ifdef OB_MK_DEQUE_MC_FOK_EN
    fok_vld = 1'b0; fok_ch = '0; fok_qty = '0;
`endif
    test_reset();
    test_push_back();
`ifdef OB_MK_DEQUE_MC_FOK_EN
    test_fok();
`endif
    test_wrap_push_front();
    test_full();
    test_reduce();
    test_illegal();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ob_mk_deque_mc.md
Name: ob_mk_deque_mc

Overview:
- Multi-channel market deque: C independent order queues (e.g. per side / per price level) in one block, each a circular buffer of depth N holding W-bit entries.
- Per-channel accumulated quantity tracked for AON/FOK screening, as in the single-channel deque.
- New over the prior generation: in-place partial fill of the head entry (ReduceHead), channel select, illegal-command error reporting, own storage (no libv_deque instance).

Parameters:
- C, 2, number of channels (≥1).
- N, 8, entries per channel (power of two, ≥2).
- W, 64, entry width in bits.
- QW, 16, quantity field width; quantity occupies entry bits [QW-1:0].
- AW, QW+$clog2(N+1), accumulated-quantity width per channel.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- cmd_vld  in  1  command valid; one command per cycle, always accepted.
- cmd_ch  in  $clog2(C) (min 1)  target channel.
- cmd_op  in  3  0 NOP, 1 PushFront, 2 PopFront, 3 PushBack, 4 PopBack, 5 ReduceHead, 6/7 reserved.
- cmd_data  in  W  push entry; for ReduceHead only bits [QW-1:0] are used, as the fill amount.
- head_vld_r  out  C  channel non-empty.
- head_r  out  C*W  head entry per channel; '0 when empty.
- tail_r  out  C*W  tail entry per channel; '0 when empty.
- empty_w  out  C  count==0.
- full_w  out  C  count==N.
- quantity_r  out  C*AW  accumulated quantity per channel.
- err_r  out  1  one-cycle pulse: previous command was illegal and dropped.

Behaviour:
- Per channel state: storage[N], rd_ptr, wr_ptr (log2 N, wrap modulo N), count (0..N), quantity.
- Reset: pointers, count and quantity zero; err_r=0; head_vld_r=0; head_r/tail_r='0. Storage is not reset and is masked by the empty gating.
- Head is storage[rd_ptr]; tail is storage[wr_ptr-1].
- All state updates on the rising clk edge when cmd_vld=1; only channel cmd_ch changes. Outputs reflect the command the following cycle (1-cycle latency). empty_w/full_w are combinational from registered count.
- PushBack: storage[wr_ptr]←data, wr_ptr++, count++, quantity += data.qty.
- PushFront: rd_ptr--, storage[rd_ptr-1]←data, count++, quantity += data.qty.
- PopFront: rd_ptr++, count--, quantity -= head.qty.
- PopBack: wr_ptr--, count--, quantity -= tail.qty.
- ReduceHead with amount a and head quantity h:
  - a==0: NOP, no error.
  - a<h: head.qty←h-a, rest of the entry unchanged; quantity -= a.
  - a==h: behaves as PopFront.
  - a>h: illegal.
- Illegal commands set err_r=1 next cycle; the command is dropped with no state change:
  - push when full;
  - pop or ReduceHead when empty;
  - ReduceHead with a>h;
  - op 6 or 7;
  - cmd_ch≥C.
- NOP: no change, err_r=0.
- Arithmetic: qty is zero-extended QW→AW. Pops cannot underflow given consistent state. Overflow is impossible by construction of AW.
- Wrap-around: pointer arithmetic is modulo N. PushFront at rd_ptr=0 writes slot N-1.
- Single-entry channel: head and tail are the same entry. ReduceHead updates both views.
- Reset mid-operation: all channels return to empty immediately (async). An in-flight command is lost.

Optional Feature:
- Macro OB_MK_DEQUE_MC_FOK_EN.
- When defined, adds:
  - port fok_vld in 1;
  - port fok_ch in $clog2(C);
  - port fok_qty in AW;
  - port fok_ok_r out 1;
  - port fok_rsp_vld_r out 1.
- One cycle after fok_vld=1, fok_rsp_vld_r=1 and fok_ok_r = (quantity_r[fok_ch] ≥ fok_qty).
- The compare uses pre-update quantity when a command to the same channel fires in the same cycle.
- fok_ch≥C gives fok_ok_r=0. Both outputs reset to 0.
- When undefined, these ports and their logic are absent.

Test Plan:
- Reset, then PushBack ch0 qty 10, 20, 30 → quantity_r[0]=60, head qty 10, tail qty 30, ch1 untouched (empty, quantity 0).
- PushFront ch1 qty 5 from rd_ptr=0, then PopBack ch1 → slot N-1 written, quantity 5→0, empty_w[1]=1, err_r=0 throughout.
- Fill ch0 to N=8 entries, 9th PushBack → full_w[0]=1, err_r pulses one cycle, count and quantity unchanged.
- ch0 head qty 10, ReduceHead 4 → head qty 6, quantity -4; ReduceHead 6 → entry popped; ReduceHead 7 against a head of 5 → err_r=1, no change.
- PopFront on empty ch1 and op 6 → err_r=1 each, no state change.
- With OB_MK_DEQUE_MC_FOK_EN, quantity_r[0]=60: fok_qty 60 → ok=1; fok_qty 61 → ok=0; assert rst_n low mid-stream → all outputs zero immediately.
